// File: rtl/updown_sweep_controller.sv
// Ping-pong sweep sequencer for an external up/down counter: load a start value,
// bounce between the high and low limits for a programmed number of round trips.
module updown_sweep_controller #(
  parameter int WIDTH = 4,
  parameter int CYC_W = 4
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Stop,
  input  logic             Pause,
  input  logic [WIDTH-1:0] Start_val,
  input  logic [WIDTH-1:0] Lo_lim,
  input  logic [WIDTH-1:0] Hi_lim,
  input  logic [CYC_W-1:0] Cycles,
  input  logic [WIDTH-1:0] Count_out,
  output logic             Load,
  output logic             Count_en,
  output logic             Up,
  output logic [WIDTH-1:0] Count_in,
  output logic             Busy,
  output logic             Done,
  output logic             Err
);

  // state   | meaning
  // IDLE    | waiting for Start; config checked on Start
  // LOAD    | one-cycle parallel load of the latched start value
  // UP      | counting up toward hi; one dwell cycle at hi
  // DOWN    | counting down toward lo; round trip ends at lo
  // DONE    | one-cycle completion pulse
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_UP   = 3'd2;
  localparam logic [2:0] ST_DOWN = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [CYC_W-1:0] ROUND_ONE = CYC_W'(1);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [WIDTH-1:0] start_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_q;
  logic [CYC_W-1:0] cycles_q;
  logic [CYC_W-1:0] round_q;
  logic [CYC_W-1:0] round_inc;
  logic             cfg_ok;
  logic             accept;
  logic             at_hi;
  logic             at_lo;
  logic             run;
  logic             last_round;

  assign cfg_ok = (Lo_lim < Hi_lim) && (Start_val >= Lo_lim) &&
                  (Start_val <= Hi_lim) && (Cycles != '0);
  assign accept = (state == ST_IDLE) && Start && cfg_ok;

  assign at_hi      = (Count_out == hi_q);
  assign at_lo      = (Count_out == lo_q);
  assign run        = !Stop && !Pause;
  assign round_inc  = round_q + ROUND_ONE;
  assign last_round = (round_inc == cycles_q);

  // Stop outranks Pause and the limit compares in every active state.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (Stop)       state_nxt = ST_IDLE;
        else if (!Pause) state_nxt = ST_UP;
      end
      ST_UP: begin
        if (Stop)               state_nxt = ST_IDLE;
        else if (run && at_hi)  state_nxt = ST_DOWN;
      end
      ST_DOWN: begin
        if (Stop)               state_nxt = ST_IDLE;
        else if (run && at_lo)  state_nxt = last_round ? ST_DONE : ST_UP;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state    <= ST_IDLE;
      start_q  <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      cycles_q <= '0;
      round_q  <= '0;
      Err      <= 1'b0;
    end else begin
      state <= state_nxt;
      Err   <= (state == ST_IDLE) && Start && !cfg_ok;
      if (accept) begin
        start_q  <= Start_val;
        lo_q     <= Lo_lim;
        hi_q     <= Hi_lim;
        cycles_q <= Cycles;
        round_q  <= '0;
      end else if ((state == ST_DOWN) && run && at_lo) begin
        round_q <= round_inc;
      end
    end
  end

  // Enable drops on the limit cycle itself, which is what gives the one-cycle dwell.
  assign Load     = (state == ST_LOAD) && !Stop;
  assign Count_en = ((state == ST_UP)   && run && !at_hi) ||
                    ((state == ST_DOWN) && run && !at_lo);
  assign Up       = (state != ST_DOWN);
  assign Count_in = start_q;
  assign Busy     = (state == ST_LOAD) || (state == ST_UP) || (state == ST_DOWN);
  assign Done     = (state == ST_DONE);

endmodule

// File: tb/tb_updown_sweep_controller.sv
// Bench for updown_sweep_controller: models the 4-bit counter, runs directed
// table vectors, hand-written corner sequences and randomized sweeps.
module tb_updown_sweep_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic [3:0] sv = '0;
  logic [3:0] lo = '0;
  logic [3:0] hi = '0;
  logic [3:0] cyc = '0;
  logic [3:0] cnt = '0;
  logic       load, cen, up, busy, done, err;
  logic [3:0] cin;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  updown_sweep_controller #(.WIDTH(4), .CYC_W(4)) dut (
    .clk(clk), .Reset(rst), .Start(start), .Stop(stop), .Pause(pause),
    .Start_val(sv), .Lo_lim(lo), .Hi_lim(hi), .Cycles(cyc),
    .Count_out(cnt), .Load(load), .Count_en(cen), .Up(up),
    .Count_in(cin), .Busy(busy), .Done(done), .Err(err)
  );

  // external 4-bit up/down counter
  always @(posedge clk) begin
    if (load)     cnt <= cin;
    else if (cen) cnt <= up ? cnt + 4'd1 : cnt - 4'd1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout", name);
  endtask

  task automatic do_start(input logic [3:0] l, h, s, c);
    @(posedge clk); #1;
    lo = l; hi = h; sv = s; cyc = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lo = 4'($urandom); hi = 4'($urandom); sv = 4'($urandom); cyc = 4'($urandom);
  endtask

  // Expected counter trajectory is built from the sweep rules: up leg from the
  // start value, then alternating full legs between the limits.
  task automatic run_sweep(input logic [3:0] l, h, s, c, input int pause_pct,
                           input logic exp_err, input int exp_busy, input logic [3:0] exp_fin);
    logic [3:0] seq[$];
    int idx, busy_n, guard;
    logic p, en_exp;
    seq = {};
    if (!exp_err) begin
      for (int v = int'(s); v <= int'(h); v++) seq.push_back(4'(v));
      for (int v = int'(h); v >= int'(l); v--) seq.push_back(4'(v));
      for (int r = 1; r < int'(c); r++) begin
        for (int v = int'(l); v <= int'(h); v++) seq.push_back(4'(v));
        for (int v = int'(h); v >= int'(l); v--) seq.push_back(4'(v));
      end
    end
    pause = 1'b0;
    do_start(l, h, s, c);
    @(negedge clk);
    if (exp_err) begin
      chk("err_pulse", err, 1);
      chk("err_busy", busy, 0);
      chk("err_load", load, 0);
      @(negedge clk);
      chk("err_width", err, 0);
      chk("err_idle", busy, 0);
      chk("err_noload", load, 0);
      return;
    end
    chk("load_strobe", load, 1);
    chk("count_in", cin, s);
    busy_n = busy ? 1 : 0;
    idx = 0;
    guard = 0;
    while (1) begin
      @(posedge clk); #1;
      p = (idx < seq.size()) && (pause_pct > 0) && ($urandom_range(99) < pause_pct);
      pause = p;
      @(negedge clk);
      if (busy) busy_n++;
      if (idx < seq.size()) begin
        en_exp = !p && (idx + 1 < seq.size()) && (seq[idx+1] != seq[idx]);
        chk("traj_count", cnt, seq[idx]);
        chk("traj_busy", busy, 1);
        chk("traj_en", cen, en_exp);
        chk("traj_nodone", done, 0);
        if (!p) idx++;
      end else begin
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_en", cen, 0);
        chk("done_hold", cnt, exp_fin);
        break;
      end
      guard++;
      if (guard > 2000) begin
        timeout("sweep");
        return;
      end
    end
    pause = 1'b0;
    if (exp_busy >= 0) chk("busy_cycles", busy_n, exp_busy);
    @(negedge clk);
    chk("done_once", done, 0);
    chk("idle_after", busy, 0);
    chk("idle_hold", cnt, exp_fin);
  endtask

  typedef struct {
    logic [3:0] l, h, s, c;
    logic       e;
    int         nbusy;
    logic [3:0] fin;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int guard;
    logic [3:0] rl, rh, rs, rc;
    logic rv;

    tbl[0] = '{4'd2, 4'd5,  4'd3,  4'd1, 1'b0, 8,  4'd2};
    tbl[1] = '{4'd0, 4'd15, 4'd12, 4'd2, 1'b0, 53, 4'd0};
    tbl[2] = '{4'd8, 4'd9,  4'd9,  4'd1, 1'b0, 4,  4'd8};
    tbl[3] = '{4'd0, 4'd1,  4'd0,  4'd3, 1'b0, 13, 4'd0};
    tbl[4] = '{4'd3, 4'd6,  4'd3,  4'd2, 1'b0, 17, 4'd3};
    tbl[5] = '{4'd5, 4'd3,  4'd4,  4'd1, 1'b1, 0,  4'd0};
    tbl[6] = '{4'd2, 4'd5,  4'd3,  4'd0, 1'b1, 0,  4'd0};
    tbl[7] = '{4'd3, 4'd6,  4'd2,  4'd1, 1'b1, 0,  4'd0};
    tbl[8] = '{4'd3, 4'd6,  4'd7,  4'd1, 1'b1, 0,  4'd0};
    tbl[9] = '{4'd4, 4'd4,  4'd4,  4'd1, 1'b1, 0,  4'd0};

    // reset values
    @(posedge clk); @(negedge clk);
    chk("rst_load", load, 0);
    chk("rst_en", cen, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_up", up, 1);
    chk("rst_cin", cin, 0);
    @(posedge clk); #1 rst = 1'b0;

    foreach (tbl[i])
      run_sweep(tbl[i].l, tbl[i].h, tbl[i].s, tbl[i].c, 0, tbl[i].e, tbl[i].nbusy, tbl[i].fin);

    // pause at 4 mid-UP, Start while busy, then Stop at 7 in DOWN
    do_start(4'd2, 4'd9, 4'd3, 4'd1);
    guard = 0;
    @(negedge clk);
    while (!(busy && up && cnt == 4'd4) && guard < 30) begin @(negedge clk); guard++; end
    if (guard >= 30) timeout("reach_4");
    pause = 1'b1;
    #1 chk("pause_en_now", cen, 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("pause_hold", cnt, 4);
      chk("pause_en", cen, 0);
      chk("pause_busy", busy, 1);
      if (k == 0) begin
        lo = 4'd5; hi = 4'd3; start = 1'b1;
      end else begin
        start = 1'b0;
        chk("start_busy_noerr", err, 0);
      end
    end
    pause = 1'b0;
    #1 chk("resume_en", cen, 1);
    @(negedge clk);
    chk("resume_5", cnt, 5);
    chk("busy_start_noerr", err, 0);
    guard = 0;
    while (!(busy && !up && cnt == 4'd7) && guard < 40) begin @(negedge clk); guard++; end
    if (guard >= 40) timeout("reach_7");
    stop = 1'b1;
    #1 chk("stop_en_now", cen, 0);
    @(posedge clk); #1 stop = 1'b0;
    @(negedge clk);
    chk("stop_busy", busy, 0);
    chk("stop_en", cen, 0);
    chk("stop_load", load, 0);
    chk("stop_nodone", done, 0);
    chk("stop_hold", cnt, 7);
    @(negedge clk);
    chk("stop_nodone2", done, 0);
    chk("stop_hold2", cnt, 7);

    // reset mid-UP, then Start_val == Hi sweep
    do_start(4'd0, 4'd15, 4'd1, 4'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_en", cen, 0);
    chk("mid_rst_load", load, 0);
    chk("mid_rst_up", up, 1);
    chk("mid_rst_cin", cin, 0);
    chk("mid_rst_done", done, 0);
    run_sweep(4'd8, 4'd9, 4'd9, 4'd1, 0, 1'b0, 4, 4'd8);

    // randomized sweeps with random pause, config checked by plain arithmetic
    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(99) < 70) begin
        rl = 4'($urandom_range(0, 14));
        rh = 4'($urandom_range(int'(rl) + 1, 15));
        rs = 4'($urandom_range(int'(rl), int'(rh)));
        rc = 4'($urandom_range(1, 3));
      end else begin
        rl = 4'($urandom); rh = 4'($urandom); rs = 4'($urandom);
        rc = 4'($urandom_range(0, 3));
      end
      rv = (int'(rl) < int'(rh)) && (int'(rs) >= int'(rl)) && (int'(rs) <= int'(rh)) && (rc != 0);
      run_sweep(rl, rh, rs, rc, 30, !rv, -1, rl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
